// File: rtl/lift_ctrl.sv
// lift_ctrl: multi-floor lift controller with a collective (keep-direction) policy.
// Call requests are latched until served. The car moves one floor per TRAVEL_TIME
// cycles. The door stays open for DOOR_TIME cycles. A call for the current floor
// while the door is open holds the door for a further DOOR_TIME cycles.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   call     in   per-floor call requests (bit i = floor i), level or pulse
//   grn      out  door open (DOOR state)
//   red      out  car travelling (MOVE state)
//   floor    out  current floor index
//   dir_up   out  current/last travel direction, 1 = up
//   pending  out  latched, unserved requests
module lift_ctrl #(
    parameter int unsigned FLOORS      = 4,
    parameter int unsigned TRAVEL_TIME = 3,
    parameter int unsigned DOOR_TIME   = 4,
    parameter int unsigned FW          = $clog2(FLOORS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLOORS-1:0] call,
    output logic              grn,
    output logic              red,
    output logic [FW-1:0]     floor,
    output logic              dir_up,
    output logic [FLOORS-1:0] pending
);

    localparam int unsigned TMax = (TRAVEL_TIME > DOOR_TIME) ? TRAVEL_TIME : DOOR_TIME;
    localparam int unsigned TW   = $clog2(TMax + 1);

    localparam logic [TW-1:0] TravelLoad = TW'(TRAVEL_TIME - 1);
    localparam logic [TW-1:0] DoorLoad   = TW'(DOOR_TIME - 1);
    localparam logic [FW-1:0] FloorTop   = FW'(FLOORS - 1);

    typedef enum logic [1:0] {StIdle, StMove, StDoor} state_e;

    state_e            state_q, state_d;
    logic [FW-1:0]     floor_q, floor_d;
    logic              dir_up_q, dir_up_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [FLOORS-1:0] pending_q, pending_d;

    logic [FLOORS-1:0] next_req;
    logic [FW-1:0]     step_floor;

    // Any request strictly above (up_side=1) or strictly below (up_side=0) floor f.
    function automatic logic req_side(input logic [FLOORS-1:0] req, input logic [FW-1:0] f,
                                      input logic up_side);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (up_side ? (i > int'(f)) : (i < int'(f))) begin
                hit = hit | req[i];
            end
        end
        return hit;
    endfunction

    function automatic logic [FLOORS-1:0] floor_mask(input logic [FW-1:0] f);
        return FLOORS'(1) << f;
    endfunction

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            timer_q   <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_req  = pending_q | call;
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        timer_d   = timer_q;
        pending_d = next_req;

        // Saturating one-floor step; the ends are never passed even if direction is stale.
        if (dir_up_q) begin
            step_floor = (floor_q == FloorTop) ? floor_q : floor_q + FW'(1);
        end else begin
            step_floor = (floor_q == '0) ? floor_q : floor_q - FW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (next_req[floor_q]) begin
                    state_d   = StDoor;
                    pending_d = next_req & ~floor_mask(floor_q);
                    timer_d   = DoorLoad;
                end else if (req_side(next_req, floor_q, dir_up_q)) begin
                    state_d = StMove;
                    timer_d = TravelLoad;
                end else if (req_side(next_req, floor_q, ~dir_up_q)) begin
                    state_d  = StMove;
                    dir_up_d = ~dir_up_q;
                    timer_d  = TravelLoad;
                end
            end
            StMove: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TW'(1);
                end else begin
                    // Arrival: decide using the floor just reached.
                    floor_d = step_floor;
                    if (next_req[step_floor]) begin
                        state_d   = StDoor;
                        pending_d = next_req & ~floor_mask(step_floor);
                        timer_d   = DoorLoad;
                    end else if (req_side(next_req, step_floor, dir_up_q)) begin
                        timer_d = TravelLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StDoor: begin
                // A call for this floor is absorbed as a door-hold, never latched.
                pending_d = next_req & ~floor_mask(floor_q);
                if (call[floor_q]) begin
                    timer_d = DoorLoad;
                end else if (timer_q == '0) begin
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs
    always_comb begin
        grn = (state_q == StDoor);
        red = (state_q == StMove);
    end

    assign floor   = floor_q;
    assign dir_up  = dir_up_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_lift_ctrl.sv
// Testbench for lift_ctrl: a table of per-cycle vectors, hand-written multi-cycle
// scenarios, and a randomized run against a behavioural model.
module tb_lift_ctrl;

    localparam int unsigned FLOORS = 4;
    localparam int unsigned TRAVEL = 3;
    localparam int unsigned DOOR   = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] call = 4'b0000;
    logic       grn;
    logic       red;
    logic [1:0] floor;
    logic       dir_up;
    logic [3:0] pending;

    lift_ctrl #(
        .FLOORS      (FLOORS),
        .TRAVEL_TIME (TRAVEL),
        .DOOR_TIME   (DOOR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .call    (call),
        .grn     (grn),
        .red     (red),
        .floor   (floor),
        .dir_up  (dir_up),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] call;
        logic       g;
        logic       r;
        logic [1:0] f;
        logic       d;
        logic [3:0] p;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic [3:0] c, input logic g, input logic r,
                                input logic [1:0] f, input logic d, input logic [3:0] p);
        vec_t v;
        v.call = c; v.g = g; v.r = r; v.f = f; v.d = d; v.p = p;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    function automatic logic [8:0] dut_out();
        return {grn, red, floor, dir_up, pending};
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        call  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive call for one rising edge, then sample just after that edge.
    task automatic step(input logic [3:0] c);
        @(negedge clk);
        call = c;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: remaining door/travel cycles instead of a state machine.
    int          m_floor;
    int          m_up;
    int          m_door;
    int          m_move;
    logic [15:0] m_pend;

    function automatic void m_reset();
        m_floor = 0; m_up = 1; m_door = 0; m_move = 0; m_pend = '0;
    endfunction

    function automatic logic m_side(input logic [15:0] req, input int f, input bit above);
        for (int i = 0; i < int'(FLOORS); i++) begin
            if (req[i] && (above ? (i > f) : (i < f))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic void m_step(input logic [3:0] c);
        logic [15:0] req;
        req = m_pend | {12'b0, c};
        if (m_door > 0) begin
            if (c[m_floor]) m_door = DOOR;
            else m_door = m_door - 1;
            req[m_floor] = 1'b0;
        end else if (m_move > 0) begin
            m_move = m_move - 1;
            if (m_move == 0) begin
                m_floor = m_floor + ((m_up != 0) ? 1 : -1);
                if (req[m_floor]) begin
                    req[m_floor] = 1'b0;
                    m_door = DOOR;
                end else if (m_side(req, m_floor, m_up != 0)) begin
                    m_move = TRAVEL;
                end
            end
        end else begin
            if (req[m_floor]) begin
                req[m_floor] = 1'b0;
                m_door = DOOR;
            end else if (m_side(req, m_floor, m_up != 0)) begin
                m_move = TRAVEL;
            end else if (m_side(req, m_floor, m_up == 0)) begin
                m_up = 1 - m_up;
                m_move = TRAVEL;
            end
        end
        m_pend = req;
    endfunction

    function automatic logic [8:0] m_out();
        return {(m_door > 0), (m_move > 0), 2'(m_floor), m_up[0], m_pend[3:0]};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         cnt;
        int         stops;
        logic       prev_g;
        logic [3:0] c;

        // Local call, up trip, then reversal back to floor 0 (cycle by cycle).
        add(4'b0001, 1, 0, 0, 1, 4'b0000);
        add(4'b0000, 1, 0, 0, 1, 4'b0000);
        add(4'b0000, 1, 0, 0, 1, 4'b0000);
        add(4'b0000, 1, 0, 0, 1, 4'b0000);
        add(4'b0000, 0, 0, 0, 1, 4'b0000);
        add(4'b0100, 0, 1, 0, 1, 4'b0100);
        add(4'b0000, 0, 1, 0, 1, 4'b0100);
        add(4'b0000, 0, 1, 0, 1, 4'b0100);
        add(4'b0000, 0, 1, 1, 1, 4'b0100);
        add(4'b0000, 0, 1, 1, 1, 4'b0100);
        add(4'b0000, 0, 1, 1, 1, 4'b0100);
        add(4'b0000, 1, 0, 2, 1, 4'b0000);
        add(4'b0000, 1, 0, 2, 1, 4'b0000);
        add(4'b0000, 1, 0, 2, 1, 4'b0000);
        add(4'b0000, 1, 0, 2, 1, 4'b0000);
        add(4'b0000, 0, 0, 2, 1, 4'b0000);
        add(4'b0001, 0, 1, 2, 0, 4'b0001);
        add(4'b0000, 0, 1, 2, 0, 4'b0001);
        add(4'b0000, 0, 1, 2, 0, 4'b0001);
        add(4'b0000, 0, 1, 1, 0, 4'b0001);
        add(4'b0000, 0, 1, 1, 0, 4'b0001);
        add(4'b0000, 0, 1, 1, 0, 4'b0001);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 0, 0, 0, 0, 4'b0000);

        do_reset();
        chk("reset_state", dut_out(), 9'b0_0_00_1_0000);

        foreach (vq[i]) begin
            step(vq[i].call);
            chk($sformatf("vec%0d", i), dut_out(),
                {vq[i].g, vq[i].r, vq[i].f, vq[i].d, vq[i].p});
        end

        // Collective: calls at 1 and 3 while heading up from 0.
        do_reset();
        step(4'b1010);
        stops  = 0;
        prev_g = grn;
        for (int n = 0; n < 60; n++) begin
            step(4'b0000);
            if (grn && !prev_g) stops = (stops << 4) | int'(floor);
            prev_g = grn;
        end
        chk("coll_stops", stops, 32'h13);
        chk("coll_end", dut_out(), 9'b0_0_11_1_0000);

        // Reversal: park at floor 3 heading up, then call floor 0.
        do_reset();
        step(4'b1000);
        for (int n = 0; n < 40 && !(floor == 2'd3 && !grn && !red); n++) step(4'b0000);
        chk("rev_at3", {floor, dir_up, grn, red}, {2'd3, 1'b1, 2'b00});
        step(4'b0001);
        chk("rev_dir", dir_up, 1'b0);
        cnt = red ? 1 : 0;
        for (int n = 0; n < 30 && red; n++) begin
            step(4'b0000);
            if (red) cnt++;
        end
        chk("rev_cycles", cnt, 9);
        chk("rev_door", {grn, floor}, {1'b1, 2'd0});

        // Door hold: call for floor 2 during door cycle 3.
        do_reset();
        step(4'b0100);
        for (int n = 0; n < 20 && !grn; n++) step(4'b0000);
        chk("hold_open", {grn, floor}, {1'b1, 2'd2});
        cnt = 1;
        for (int n = 0; n < 20 && grn; n++) begin
            c = (cnt == 3) ? 4'b0100 : 4'b0000;
            step(c);
            if (c != 4'b0000) chk("hold_pend", pending[2], 1'b0);
            if (grn) cnt++;
        end
        chk("hold_cycles", cnt, 7);

        // Asynchronous reset mid-MOVE at floor 2.
        do_reset();
        step(4'b1000);
        for (int n = 0; n < 20 && !(floor == 2'd2 && red); n++) step(4'b0000);
        chk("rst_pre", {floor, red, pending}, {2'd2, 1'b1, 4'b1000});
        #2 reset = 1'b0;
        #1 chk("rst_async", dut_out(), 9'b0_0_00_1_0000);
        @(negedge clk);
        reset = 1'b1;

        // Randomized calls against the model.
        do_reset();
        m_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) c = 4'($urandom_range(1, 15));
            else c = 4'b0000;
            step(c);
            m_step(c);
            chk("rand", dut_out(), m_out());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
